user_edge_sched: RTL and testbench
==================================

# user_edge_sched

Register-programmed job sequencer for the edge accelerator. Software writes a base address and word count over an OBI subordinate port, then sets start. The block issues one OBI read per word to the accelerator's subordinate port, which triggers the accelerator's read-shift-writeback, and counts completions. It sits in the user domain between the croc_domain crossbar (configuration) and the accelerator's subordinate port (work), and raises a level interrupt when the job ends.

## Interface
- ADDR_WIDTH, 16, address width on both OBI ports
- DATA_WIDTH, 32, data width on both OBI ports
- ID_WIDTH, 4, OBI ID width
- CNT_WIDTH, 16, width of the word-count and progress registers
- JOB_ID, 4'hA, constant ID driven on every manager request
- clk_i  in  1  single clock
- rst_ni  in  1  reset, asynchronous, active-low
- sbr_obi_req_i / addr_i / wdata_i / we_i / id_i  in  1/ADDR_WIDTH/DATA_WIDTH/1/ID_WIDTH  configuration access from croc_domain
- sbr_obi_gnt_o / rvalid_o / rdata_o / rid_o / err_o  out  1/1/DATA_WIDTH/ID_WIDTH/1  configuration response
- mgr_obi_req_o / addr_o / wdata_o / we_o / id_o  out  1/ADDR_WIDTH/DATA_WIDTH/1/ID_WIDTH  job requests to the accelerator
- mgr_obi_gnt_i / rvalid_i / rdata_i / rid_i / err_i  in  1/1/DATA_WIDTH/ID_WIDTH/1  accelerator response
- irq_o  out  1  job-end interrupt, level

## Operation
- Register map (byte offsets, addr[4:0]; higher bits ignored):
  - 0x00 CTRL: bit0 START, write-1 pulse, reads 0. bit1 IRQ_EN, R/W.
  - 0x04 STATUS: bit0 BUSY (RO). bit1 DONE, sticky, W1C. bit2 ERR, sticky, W1C.
  - 0x08 BASE: R/W. Bits [1:0] are forced to 0.
  - 0x0C COUNT: R/W, CNT_WIDTH bits, number of words.
  - 0x10 PROGRESS: RO, words completed in the current or last job.
- Any other offset returns err=1 with rdata=0. Writes to those offsets have no effect.
- Writes to BASE or COUNT while BUSY are accepted but ignored, because the job runs on latched copies.
- START while BUSY is ignored.
- A START write also clears DONE, ERR and PROGRESS.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
  - IDLE -> ISSUE on START with COUNT≠0.
  - IDLE -> FINISH on START with COUNT=0. No manager request is issued.
  - ISSUE: mgr req=1, we=0, wdata=0, id=JOB_ID, addr = base_q + 4·idx, modulo 2^ADDR_WIDTH (wraps). Go to WAIT on gnt.
  - WAIT: on rvalid, idx and PROGRESS increment.
    - If err_i=1: set ERR, go to FINISH.
    - Otherwise, if idx+1 = count_q, go to FINISH; else go to ISSUE.
  - FINISH: set DONE and go to IDLE, taking one cycle.
- rdata_i from the manager port is discarded.
- rid_i is not checked. At most one request is outstanding.
- irq_o = IRQ_EN & (DONE | ERR), registered.
- BUSY = state≠IDLE.

## Timing
- Reset values:
  - All outputs are 0.
  - mgr addr/wdata/id are 0.
  - CTRL, STATUS, BASE, COUNT and PROGRESS are 0.
  - State is IDLE.
- Reset mid-job returns the block to IDLE immediately. No request is held.
- Subordinate port:
  - gnt_o = req_i, combinational, so every access is granted in the same cycle.
  - rvalid_o pulses 1 cycle after the grant, with rid_o = the captured ID. This applies to writes as well.
  - The register update from a write takes effect on the grant edge.
- A START granted at edge N gives BUSY=1 and mgr_req_o=1 in cycle N+1.
- mgr_req_o and addr are held stable until gnt_i.
- req drops in the cycle after the grant edge.
- The next request rises in the cycle after the rvalid edge.
- Minimum per word: 1 issue cycle + accelerator latency.
- The last rvalid at edge M gives FINISH in cycle M+1, and DONE=1 and BUSY=0 in cycle M+2. irq_o rises at M+3.
- If a subordinate W1C of DONE coincides with the FINISH set, the set wins.

## Structure
- Package user_edge_pkg holds:
  - the register offset localparams (REG_CTRL, REG_STATUS, REG_BASE, REG_COUNT, REG_PROGRESS);
  - the CTRL/STATUS bit indices;
  - the sched_state_t enum (2 bits).
- Sub-module user_edge_sched_regs implements the subordinate-port register file and the response logic. It exports start_pulse, base, count and irq_en, and takes busy, done_set, err_set and progress as inputs.
- The top level contains the FSM, the index counter and the manager-port drive.

## Test plan
- Reset, then read STATUS: rdata=0, err=0, irq_o=0, mgr_req_o=0.
- BASE=0x0100, COUNT=3, CTRL=0x3, accelerator with gnt after 1 cycle and rvalid 2 cycles later.
  - Required: reads at 0x0100, 0x0104, 0x0108 with id=0xA.
  - Required: PROGRESS=3 and STATUS=0x2; irq_o=1.
  - Then W1C DONE gives irq_o=0.
- COUNT=0, START: no mgr_req_o ever. STATUS reads 0x2 two cycles after the grant.
- BASE=0xFFF8, COUNT=4, with ADDR_WIDTH=16: addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- COUNT=5, err_i=1 on the second rvalid: exactly 2 requests, STATUS=0x6, PROGRESS=2.
- Mid-job boundary cases:
  - Write COUNT=9 and START mid-job: the job still runs the original count.
  - Assert rst_ni low mid-WAIT: all outputs 0 in the same cycle.
  - Access offset 0x14: err_o=1.

Source files
------------

// File: rtl/user_edge_pkg.sv
// Shared register map, bit positions and FSM encoding for the edge job sequencer.
package user_edge_pkg;

   localparam logic [4:0] REG_CTRL     = 5'h00;
   localparam logic [4:0] REG_STATUS   = 5'h04;
   localparam logic [4:0] REG_BASE     = 5'h08;
   localparam logic [4:0] REG_COUNT    = 5'h0C;
   localparam logic [4:0] REG_PROGRESS = 5'h10;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_ERR    = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_FINISH
   } sched_state_t;

   function automatic logic reg_hit(input logic [4:0] off);
      return (off == REG_CTRL) || (off == REG_STATUS) || (off == REG_BASE) ||
             (off == REG_COUNT) || (off == REG_PROGRESS);
   endfunction

endpackage

// File: rtl/user_edge_sched_if.sv
// OBI request/response bundle; master drives the request, slave returns grant and response.
interface user_edge_sched_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  we;
   logic [ID_WIDTH-1:0]   id;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [ID_WIDTH-1:0]   rid;
   logic                  err;

   modport master (output req, addr, wdata, we, id, input gnt, rvalid, rdata, rid, err);
   modport slave  (input req, addr, wdata, we, id, output gnt, rvalid, rdata, rid, err);
endinterface

// File: rtl/user_edge_sched_regs.sv
// Configuration register file: every access is granted combinationally, response one cycle later.
// Sticky DONE/ERR with W1C; a hardware set in the same cycle as a clear wins.
module user_edge_sched_regs
   import user_edge_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   user_edge_sched_if.slave      sbr,
   input  logic                  busy,
   input  logic                  done_set,
   input  logic                  err_set,
   input  logic [CNT_WIDTH-1:0]  progress,
   output logic                  start_pulse,
   output logic [ADDR_WIDTH-1:0] base,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  irq_en,
   output logic                  irq
);

   logic [4:0]            off;
   logic                  wr;
   logic                  done_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  rvalid_q;
   logic                  rsp_err_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [ID_WIDTH-1:0]   rid_q;
   logic                  unused_bits;

   assign off         = sbr.addr[4:0];
   assign wr          = sbr.req & sbr.we;
   assign sbr.gnt     = sbr.req;
   assign start_pulse = wr && (off == REG_CTRL) && sbr.wdata[CTRL_START] && !busy;
   assign unused_bits = ^{sbr.addr, sbr.wdata};

   always_comb begin
      rd_val = '0;
      case (off)
         REG_CTRL:     rd_val[CTRL_IRQ_EN] = irq_en;
         REG_STATUS: begin
            rd_val[STAT_BUSY] = busy;
            rd_val[STAT_DONE] = done_q;
            rd_val[STAT_ERR]  = err_q;
         end
         REG_BASE:     rd_val[ADDR_WIDTH-1:0] = base;
         REG_COUNT:    rd_val[CNT_WIDTH-1:0]  = count;
         REG_PROGRESS: rd_val[CNT_WIDTH-1:0]  = progress;
         default:      rd_val = '0;
      endcase
   end

   // BASE/COUNT are frozen while a job runs; the FSM works on its own latched copies
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en <= 1'b0;
         base   <= '0;
         count  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr && off == REG_CTRL)
            irq_en <= sbr.wdata[CTRL_IRQ_EN];
         if (wr && off == REG_BASE && !busy)
            base <= {sbr.wdata[ADDR_WIDTH-1:2], 2'b00};
         if (wr && off == REG_COUNT && !busy)
            count <= sbr.wdata[CNT_WIDTH-1:0];

         if (done_set)
            done_q <= 1'b1;
         else if (start_pulse || (wr && off == REG_STATUS && sbr.wdata[STAT_DONE]))
            done_q <= 1'b0;

         if (err_set)
            err_q <= 1'b1;
         else if (start_pulse || (wr && off == REG_STATUS && sbr.wdata[STAT_ERR]))
            err_q <= 1'b0;

         irq <= irq_en & (done_q | err_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q  <= 1'b0;
         rsp_err_q <= 1'b0;
         rdata_q   <= '0;
         rid_q     <= '0;
      end else begin
         rvalid_q <= sbr.req;
         if (sbr.req) begin
            rid_q     <= sbr.id;
            rsp_err_q <= !reg_hit(off);
            rdata_q   <= sbr.we ? '0 : rd_val;
         end else begin
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
         end
      end
   end

   assign sbr.rvalid = rvalid_q;
   assign sbr.rdata  = rdata_q;
   assign sbr.rid    = rid_q;
   assign sbr.err    = rsp_err_q;

endmodule

// File: rtl/user_edge_sched.sv
// Job sequencer: one OBI read per word to the accelerator, single outstanding request.
// Request held until gnt; next request issued the cycle after each rvalid.
module user_edge_sched
   import user_edge_pkg::*;
#(
   parameter int                ADDR_WIDTH = 16,
   parameter int                DATA_WIDTH = 32,
   parameter int                ID_WIDTH   = 4,
   parameter int                CNT_WIDTH  = 16,
   parameter logic [ID_WIDTH-1:0] JOB_ID   = 4'hA
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   user_edge_sched_if.slave  sbr,
   user_edge_sched_if.master mgr,
   output logic              irq_o
);

   sched_state_t          state_q, state_d;
   logic [CNT_WIDTH-1:0]  idx_q;
   logic [CNT_WIDTH-1:0]  count_l;
   logic [ADDR_WIDTH-1:0] base_l;
   logic                  start_pulse;
   logic [ADDR_WIDTH-1:0] base;
   logic [CNT_WIDTH-1:0]  count;
   logic                  irq_en;
   logic                  busy;
   logic                  done_set;
   logic                  err_set;
   logic                  load;
   logic                  step;
   logic                  issue;
   logic                  unused_mgr;

   assign busy       = (state_q != ST_IDLE);
   assign unused_mgr = ^{mgr.rdata, mgr.rid, irq_en};

   user_edge_sched_regs #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_regs (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .sbr         (sbr),
      .busy        (busy),
      .done_set    (done_set),
      .err_set     (err_set),
      .progress    (idx_q),
      .start_pulse (start_pulse),
      .base        (base),
      .count       (count),
      .irq_en      (irq_en),
      .irq         (irq_o)
   );

   always_comb begin
      state_d  = state_q;
      done_set = 1'b0;
      err_set  = 1'b0;
      load     = 1'b0;
      step     = 1'b0;
      issue    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_pulse) begin
               load    = 1'b1;
               state_d = (count == '0) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue = 1'b1;
            if (mgr.gnt)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mgr.rvalid) begin
               step = 1'b1;
               if (mgr.err) begin
                  err_set = 1'b1;
                  state_d = ST_FINISH;
               end else if (CNT_WIDTH'(idx_q + 1'b1) == count_l) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FINISH: begin
            done_set = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // idx doubles as the PROGRESS register: it is cleared only by an accepted START
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         count_l <= '0;
         base_l  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            idx_q   <= '0;
            count_l <= count;
            base_l  <= base;
         end else if (step) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign mgr.req   = issue;
   assign mgr.we    = 1'b0;
   assign mgr.wdata = '0;
   assign mgr.id    = issue ? JOB_ID : '0;
   assign mgr.addr  = issue ? base_l + ADDR_WIDTH'({idx_q, 2'b00}) : '0;

endmodule

// File: tb/tb_user_edge_sched.sv
// Directed bench for user_edge_sched with a fixed-latency accelerator responder.
module tb_user_edge_sched;

   logic clk_i;
   logic rst_ni;
   logic irq;

   user_edge_sched_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4)) sbr ();
   user_edge_sched_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4)) mgr ();

   user_edge_sched #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (32),
      .ID_WIDTH   (4),
      .CNT_WIDTH  (16),
      .JOB_ID     (4'hA)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .sbr    (sbr),
      .mgr    (mgr),
      .irq_o  (irq)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_req = 0;
   int          rsp_n = 0;
   int          err_at = 0;
   int          acc_wait = 0;
   int          req_cycles = 0;
   logic        req_seen = 1'b0;
   logic [3:0]  tid = 4'h0;
   logic [15:0] addr_log [16];
   logic [3:0]  id_log [16];
   logic [31:0] d;
   logic        e;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // accelerator: grant one cycle after req is seen, rvalid three cycles after the grant edge
   always @(posedge clk_i) begin
      #1;
      if (!rst_ni) begin
         mgr.gnt = 1'b0; mgr.rvalid = 1'b0; mgr.err = 1'b0;
         acc_wait = 0; req_seen = 1'b0;
      end else begin
         mgr.rvalid = 1'b0;
         mgr.err    = 1'b0;
         if (mgr.gnt) begin
            mgr.gnt  = 1'b0;
            acc_wait = 2;
         end else if (acc_wait > 0) begin
            acc_wait--;
            if (acc_wait == 0) begin
               rsp_n++;
               mgr.rvalid = 1'b1;
               mgr.err    = (rsp_n == err_at);
            end
         end else if (mgr.req) begin
            if (req_seen) begin
               mgr.gnt  = 1'b1;
               req_seen = 1'b0;
               if (n_req < 16) begin
                  addr_log[n_req] = mgr.addr;
                  id_log[n_req]   = mgr.id;
               end
               n_req++;
            end else begin
               req_seen = 1'b1;
            end
         end
      end
   end

   always @(negedge clk_i) if (mgr.req) req_cycles++;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic w, input logic [15:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
      sbr.req = 1'b1; sbr.we = w; sbr.addr = a; sbr.wdata = wd; sbr.id = tid;
      #1;
      check("sbr_gnt", {31'b0, sbr.gnt}, 32'h1);
      @(posedge clk_i);
      #1;
      sbr.req = 1'b0; sbr.we = 1'b0; sbr.addr = '0; sbr.wdata = '0;
      check("sbr_rvalid", {31'b0, sbr.rvalid}, 32'h1);
      check("sbr_rid", {28'b0, sbr.rid}, {28'b0, tid});
      rd  = sbr.rdata;
      er  = sbr.err;
      tid = tid + 4'h1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] wd);
      logic [31:0] rd;
      logic er;
      access(1'b1, a, wd, rd, er);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic er;
      access(1'b0, a, 32'h0, rd, er);
      check(tag, rd, exp);
      check({tag, "_err"}, {31'b0, er}, 32'h0);
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] rd;
      logic er;
      rd = 32'h1;
      for (int i = 0; i < 100 && rd[0]; i++) access(1'b0, 16'h0004, 32'h0, rd, er);
      check(tag, {31'b0, rd[0]}, 32'h0);
   endtask

   task automatic new_job(input int err_pos);
      n_req = 0; rsp_n = 0; err_at = err_pos; req_cycles = 0;
   endtask

   initial begin
      rst_ni = 1'b0;
      sbr.req = 1'b0; sbr.we = 1'b0; sbr.addr = '0; sbr.wdata = '0; sbr.id = '0;
      mgr.gnt = 1'b0; mgr.rvalid = 1'b0; mgr.err = 1'b0;
      mgr.rdata = 32'hDEAD_BEEF; mgr.rid = 4'h3;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_mgr_req", {31'b0, mgr.req}, 32'h0);
      check("rst_mgr_addr_id", {12'b0, mgr.id, mgr.addr}, 32'h0);
      check("rst_sbr_rvalid", {31'b0, sbr.rvalid}, 32'h0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      rd_chk("rst_status", 16'h0004, 32'h0);

      // three-word job with interrupt enabled
      new_job(0);
      wr(16'h0008, 32'h0000_0100);
      wr(16'h000C, 32'd3);
      wr(16'h0000, 32'h3);
      check("start_req_next_cycle", {31'b0, mgr.req}, 32'h1);
      wait_idle("job3_idle");
      check("job3_nreq", n_req, 3);
      check("job3_addr0", {16'b0, addr_log[0]}, 32'h0100);
      check("job3_addr1", {16'b0, addr_log[1]}, 32'h0104);
      check("job3_addr2", {16'b0, addr_log[2]}, 32'h0108);
      check("job3_id", {20'b0, id_log[0], id_log[1], id_log[2]}, 32'hAAA);
      rd_chk("job3_progress", 16'h0010, 32'd3);
      rd_chk("job3_status", 16'h0004, 32'h2);
      check("job3_irq", {31'b0, irq}, 32'h1);
      rd_chk("ctrl_readback", 16'h0000, 32'h2);
      wr(16'h0004, 32'h2);
      @(posedge clk_i);
      #1;
      check("w1c_irq", {31'b0, irq}, 32'h0);
      rd_chk("w1c_status", 16'h0004, 32'h0);

      // zero-length job: FINISH straight from IDLE, no manager traffic
      new_job(0);
      wr(16'h000C, 32'd0);
      wr(16'h0000, 32'h1);
      rd_chk("cnt0_status_n1", 16'h0004, 32'h1);
      rd_chk("cnt0_status_n2", 16'h0004, 32'h2);
      repeat (4) @(posedge clk_i);
      #1;
      check("cnt0_no_req", req_cycles, 0);
      check("cnt0_irq_masked", {31'b0, irq}, 32'h0);

      // address wrap at 2^16
      new_job(0);
      wr(16'h0008, 32'h0000_FFF8);
      wr(16'h000C, 32'd4);
      wr(16'h0000, 32'h1);
      wait_idle("wrap_idle");
      check("wrap_nreq", n_req, 4);
      check("wrap_addrs01", {addr_log[0], addr_log[1]}, 32'hFFF8_FFFC);
      check("wrap_addrs23", {addr_log[2], addr_log[3]}, 32'h0000_0004);

      // accelerator error on the second response
      new_job(2);
      wr(16'h000C, 32'd5);
      wr(16'h0000, 32'h3);
      wait_idle("err_idle");
      check("err_nreq", n_req, 2);
      rd_chk("err_status", 16'h0004, 32'h6);
      rd_chk("err_progress", 16'h0010, 32'd2);
      check("err_irq", {31'b0, irq}, 32'h1);
      wr(16'h0004, 32'h6);
      rd_chk("err_w1c_status", 16'h0004, 32'h0);

      // reconfiguration and re-START while busy are ignored
      new_job(0);
      wr(16'h0008, 32'h0000_0200);
      wr(16'h000C, 32'd3);
      wr(16'h0000, 32'h1);
      wr(16'h000C, 32'd9);
      wr(16'h0008, 32'h0000_0300);
      wr(16'h0000, 32'h1);
      wait_idle("busy_idle");
      check("busy_nreq", n_req, 3);
      check("busy_addr2", {16'b0, addr_log[2]}, 32'h0208);
      rd_chk("busy_count_kept", 16'h000C, 32'd3);
      rd_chk("busy_base_kept", 16'h0008, 32'h0200);
      rd_chk("busy_progress", 16'h0010, 32'd3);

      // asynchronous reset while waiting for a response
      new_job(0);
      wr(16'h0000, 32'h3);
      @(posedge clk_i);
      @(posedge clk_i);
      #3;
      check("pre_rst_in_wait", acc_wait, 2);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_mgr", {mgr.req, mgr.we, mgr.id, mgr.addr, mgr.wdata[9:0]}, 32'h0);
      check("rst_mid_sbr", {irq, sbr.rvalid, sbr.err, sbr.rid, sbr.rdata[24:0]}, 32'h0);
      @(posedge clk_i);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
      req_cycles = 0;
      @(posedge clk_i);
      #1;
      rd_chk("rst_mid_status", 16'h0004, 32'h0);
      rd_chk("rst_mid_ctrl", 16'h0000, 32'h0);
      rd_chk("rst_mid_count", 16'h000C, 32'h0);
      rd_chk("rst_mid_progress", 16'h0010, 32'h0);
      check("rst_mid_no_req", req_cycles, 0);

      // decode: upper address bits ignored, low BASE bits forced, unmapped offsets error
      wr(16'h0028, 32'h0000_1237);
      rd_chk("base_alias", 16'h0008, 32'h1234);
      access(1'b0, 16'h0014, 32'h0, d, e);
      check("bad_rd_err", {31'b0, e}, 32'h1);
      check("bad_rd_data", d, 32'h0);
      access(1'b1, 16'h0034, 32'hFFFF_FFFF, d, e);
      check("bad_wr_err", {31'b0, e}, 32'h1);
      rd_chk("bad_wr_noeffect", 16'h0000, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
